// File: rtl/input_port_buffer_if.sv
// Link-side and read-side signals of input_port_buffer grouped into one bundle.
// The slave modport is the buffer's view; the master modport is the driver's view.
interface input_port_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic                  regularFIFO_read;
  logic                  priorityFIFO_read;
  logic                  FIFOsel;
  logic                  regularFIFO_empty;
  logic                  priorityFIFO_empty;
  logic [2:0]            head;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  pkt_err;

  modport master (
    output data_in, valid_in, regularFIFO_read, priorityFIFO_read, FIFOsel,
    input  ready_in, regularFIFO_empty, priorityFIFO_empty, head, data_out, pkt_err
  );

  modport slave (
    input  data_in, valid_in, regularFIFO_read, priorityFIFO_read, FIFOsel,
    output ready_in, regularFIFO_empty, priorityFIFO_empty, head, data_out, pkt_err
  );
endinterface

// File: rtl/input_port_buffer.sv
// Router input port: steers packets into a regular or a priority show-ahead FIFO.
// Optional occupancy outputs are enabled by defining INPUT_BUFFER_STATS_EN.
module input_port_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef INPUT_BUFFER_STATS_EN
  output logic [$clog2(DEPTH):0]   regular_count,
  output logic [$clog2(DEPTH):0]   priority_count,
`endif
  input_port_buffer_if.slave       bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] T_HEAD   = 3'b100;
  localparam logic [2:0] T_BODY   = 3'b101;
  localparam logic [2:0] T_TAIL   = 3'b110;
  localparam logic [2:0] T_SINGLE = 3'b111;

  typedef enum logic [1:0] {IDLE, PRIO_PKT, REG_PKT} state_e;

  state_e                state_q, state_d;
  logic                  pktErr_q, pktErr_d;
  logic [DATA_WIDTH-1:0] regMem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] prioMem_q [DEPTH];
  logic [PTR_W-1:0]      regWrPtr_q, regWrPtr_d, regRdPtr_q, regRdPtr_d;
  logic [PTR_W-1:0]      prioWrPtr_q, prioWrPtr_d, prioRdPtr_q, prioRdPtr_d;
  logic [CNT_W-1:0]      regCnt_q, regCnt_d, prioCnt_q, prioCnt_d;

  logic [2:0] flitType;
  logic       flitPrio, isHead, isBody, isTail, isSingle;
  logic       regFull, prioFull, regEmpty, prioEmpty;
  logic       toReg, toPrio, readyIn, accept;
  logic       regWr, prioWr, regPop, prioPop;

  assign flitType = bus.data_in[DATA_WIDTH-1 -: 3];
  assign flitPrio = bus.data_in[DATA_WIDTH-4];
  assign isHead   = (flitType == T_HEAD);
  assign isBody   = (flitType == T_BODY);
  assign isTail   = (flitType == T_TAIL);
  assign isSingle = (flitType == T_SINGLE);

  assign regEmpty  = (regCnt_q == '0);
  assign prioEmpty = (prioCnt_q == '0);
  assign regFull   = (regCnt_q == CNT_W'(DEPTH));
  assign prioFull  = (prioCnt_q == CNT_W'(DEPTH));

  // Flits with no target FIFO are out of protocol: accepted, dropped and flagged.
  always_comb begin
    state_d  = state_q;
    pktErr_d = pktErr_q;
    toReg    = 1'b0;
    toPrio   = 1'b0;
    case (state_q)
      IDLE: begin
        if (isHead || isSingle) begin
          toPrio = flitPrio;
          toReg  = ~flitPrio;
        end
      end
      PRIO_PKT: toPrio = isBody || isTail;
      REG_PKT:  toReg  = isBody || isTail;
      default:  state_d = IDLE;
    endcase
    readyIn = toReg ? ~regFull : (toPrio ? ~prioFull : 1'b1);
    accept  = bus.valid_in & readyIn;
    if (accept) begin
      if (!toReg && !toPrio) begin
        pktErr_d = 1'b1;
      end else if (state_q == IDLE && isHead) begin
        state_d = flitPrio ? PRIO_PKT : REG_PKT;
      end else if (state_q != IDLE && isTail) begin
        state_d = IDLE;
      end
    end
  end

  assign regWr   = accept & toReg;
  assign prioWr  = accept & toPrio;
  assign regPop  = bus.regularFIFO_read & ~regEmpty;
  assign prioPop = bus.priorityFIFO_read & ~prioEmpty;

  assign regWrPtr_d  = regWrPtr_q + PTR_W'(regWr);
  assign regRdPtr_d  = regRdPtr_q + PTR_W'(regPop);
  assign regCnt_d    = regCnt_q + CNT_W'(regWr) - CNT_W'(regPop);
  assign prioWrPtr_d = prioWrPtr_q + PTR_W'(prioWr);
  assign prioRdPtr_d = prioRdPtr_q + PTR_W'(prioPop);
  assign prioCnt_d   = prioCnt_q + CNT_W'(prioWr) - CNT_W'(prioPop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pktErr_q    <= 1'b0;
      regWrPtr_q  <= '0;
      regRdPtr_q  <= '0;
      regCnt_q    <= '0;
      prioWrPtr_q <= '0;
      prioRdPtr_q <= '0;
      prioCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pktErr_q    <= pktErr_d;
      regWrPtr_q  <= regWrPtr_d;
      regRdPtr_q  <= regRdPtr_d;
      regCnt_q    <= regCnt_d;
      prioWrPtr_q <= prioWrPtr_d;
      prioRdPtr_q <= prioRdPtr_d;
      prioCnt_q   <= prioCnt_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (!rst && regWr) begin
      regMem_q[regWrPtr_q] <= bus.data_in;
    end
    if (!rst && prioWr) begin
      prioMem_q[prioWrPtr_q] <= bus.data_in;
    end
  end

  assign bus.ready_in           = readyIn;
  assign bus.regularFIFO_empty  = regEmpty;
  assign bus.priorityFIFO_empty = prioEmpty;
  assign bus.pkt_err            = pktErr_q;
  assign bus.head = regEmpty ? 3'b000 : regMem_q[regRdPtr_q][DATA_WIDTH-1 -: 3];
  assign bus.data_out = bus.FIFOsel
                      ? (prioEmpty ? '0 : prioMem_q[prioRdPtr_q])
                      : (regEmpty  ? '0 : regMem_q[regRdPtr_q]);

`ifdef INPUT_BUFFER_STATS_EN
  assign regular_count  = regCnt_q;
  assign priority_count = prioCnt_q;
`endif
endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed protocol scenarios followed
// by random traffic, all compared against a queue-based packet model.
module tb_input_port_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam logic [2:0] T_HEAD   = 3'b100;
  localparam logic [2:0] T_BODY   = 3'b101;
  localparam logic [2:0] T_TAIL   = 3'b110;
  localparam logic [2:0] T_SINGLE = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] regQ[$];
  logic [DW-1:0] prioQ[$];
  bit            mInPkt, mPktPrio, mErr;

`ifdef INPUT_BUFFER_STATS_EN
  logic [$clog2(DEPTH):0] regularCount, priorityCount;
`endif

  input_port_buffer_if #(.DATA_WIDTH(DW)) bus();

  input_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef INPUT_BUFFER_STATS_EN
    .regular_count  (regularCount),
    .priority_count (priorityCount),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [DW-1:0] mk(input logic [2:0] t, input logic p);
    logic [DW-5:0] payload;
    payload = (DW-4)'($urandom);
    return {t, p, payload};
  endfunction

  // 0 = dropped, 1 = regular FIFO, 2 = priority FIFO
  function automatic int modelTarget(input logic [DW-1:0] d);
    logic [2:0] t;
    t = d[DW-1 -: 3];
    if (!mInPkt) begin
      if (t == T_HEAD || t == T_SINGLE) return d[DW-4] ? 2 : 1;
      return 0;
    end
    if (t == T_BODY || t == T_TAIL) return mPktPrio ? 2 : 1;
    return 0;
  endfunction

  function automatic bit modelReady(input logic [DW-1:0] d);
    int tgt;
    tgt = modelTarget(d);
    if (tgt == 1) return regQ.size() < DEPTH;
    if (tgt == 2) return prioQ.size() < DEPTH;
    return 1'b1;
  endfunction

  task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [DW-1:0] expOut;
    logic [2:0]    expHead;
    expHead = (regQ.size() == 0) ? 3'b000 : regQ[0][DW-1 -: 3];
    if (bus.FIFOsel) expOut = (prioQ.size() == 0) ? '0 : prioQ[0];
    else             expOut = (regQ.size() == 0) ? '0 : regQ[0];
    checkVal({tag, ".ready_in"}, DW'(bus.ready_in), DW'(modelReady(bus.data_in)));
    checkVal({tag, ".reg_empty"}, DW'(bus.regularFIFO_empty), DW'(regQ.size() == 0));
    checkVal({tag, ".prio_empty"}, DW'(bus.priorityFIFO_empty), DW'(prioQ.size() == 0));
    checkVal({tag, ".head"}, DW'(bus.head), DW'(expHead));
    checkVal({tag, ".data_out"}, bus.data_out, expOut);
    checkVal({tag, ".pkt_err"}, DW'(bus.pkt_err), DW'(mErr));
`ifdef INPUT_BUFFER_STATS_EN
    checkVal({tag, ".reg_count"}, DW'(regularCount), DW'(regQ.size()));
    checkVal({tag, ".prio_count"}, DW'(priorityCount), DW'(prioQ.size()));
`endif
  endtask

  task automatic modelEdge();
    int         tgt;
    bit         rdy;
    logic [2:0] t;
    tgt = modelTarget(bus.data_in);
    rdy = modelReady(bus.data_in);
    t   = bus.data_in[DW-1 -: 3];
    if (bus.regularFIFO_read && regQ.size() > 0) void'(regQ.pop_front());
    if (bus.priorityFIFO_read && prioQ.size() > 0) void'(prioQ.pop_front());
    if (bus.valid_in && rdy) begin
      if (tgt == 0) begin
        mErr = 1'b1;
      end else begin
        if (tgt == 1) regQ.push_back(bus.data_in);
        else          prioQ.push_back(bus.data_in);
        if (!mInPkt && t == T_HEAD) begin
          mInPkt   = 1'b1;
          mPktPrio = bus.data_in[DW-4];
        end else if (mInPkt && t == T_TAIL) begin
          mInPkt = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [DW-1:0] d,
                               input logic rdR, input logic rdP, input logic sel);
    @(negedge clk);
    bus.valid_in          = v;
    bus.data_in           = d;
    bus.regularFIFO_read  = rdR;
    bus.priorityFIFO_read = rdP;
    bus.FIFOsel           = sel;
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst                   = 1'b1;
    bus.valid_in          = 1'b0;
    bus.regularFIFO_read  = 1'b0;
    bus.priorityFIFO_read = 1'b0;
    @(posedge clk);
    regQ.delete();
    prioQ.delete();
    mInPkt   = 1'b0;
    mPktPrio = 1'b0;
    mErr     = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] prioHead;
    logic          v, rdR, rdP, sel;
    logic [2:0]    t;

    bus.data_in           = '0;
    bus.valid_in          = 1'b0;
    bus.regularFIFO_read  = 1'b0;
    bus.priorityFIFO_read = 1'b0;
    bus.FIFOsel           = 1'b0;

    // Reset state, including ready for a would-be priority head
    doReset();
    applyStimulus("reset", 1'b0, mk(T_HEAD, 1'b1), 1'b0, 1'b0, 1'b0);
    checkVal("reset.ready_in", DW'(bus.ready_in), DW'(1'b1));

    // Regular packet
    applyStimulus("reg_head", 1'b1, mk(T_HEAD, 1'b0), 1'b0, 1'b0, 1'b0);
    applyStimulus("reg_body", 1'b1, mk(T_BODY, 1'b0), 1'b0, 1'b0, 1'b0);
    checkVal("reg_after_head.empty", DW'(bus.regularFIFO_empty), DW'(1'b0));
    checkVal("reg_after_head.head", DW'(bus.head), DW'(T_HEAD));
    applyStimulus("reg_tail", 1'b1, mk(T_TAIL, 1'b0), 1'b0, 1'b0, 1'b0);
    checkVal("reg_pkt.prio_empty", DW'(bus.priorityFIFO_empty), DW'(1'b1));

    // Priority packet while regular traffic is queued
    prioHead = mk(T_HEAD, 1'b1);
    applyStimulus("prio_head", 1'b1, prioHead, 1'b0, 1'b0, 1'b1);
    applyStimulus("prio_tail", 1'b1, mk(T_TAIL, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("prio_show", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkVal("prio_show.head_flit", bus.data_out, prioHead);

    // Body in IDLE is dropped and the error sticks
    applyStimulus("idle_body", 1'b1, mk(T_BODY, 1'b0), 1'b0, 1'b0, 1'b0);
    applyStimulus("err_sticky0", 1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkVal("idle_body.pkt_err", DW'(bus.pkt_err), DW'(1'b1));
    applyStimulus("err_sticky1", 1'b0, '0, 1'b1, 1'b1, 1'b1);
    applyStimulus("err_sticky2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill regular FIFO to DEPTH, then backpressure and pop-does-not-bypass-full
    doReset();
    applyStimulus("fill_head", 1'b1, mk(T_HEAD, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 2; i++)
      applyStimulus("fill_body", 1'b1, mk(T_BODY, 1'b0), 1'b0, 1'b0, 1'b0);
    applyStimulus("fill_tail", 1'b1, mk(T_TAIL, 1'b0), 1'b0, 1'b0, 1'b0);
    applyStimulus("full_pop", 1'b1, mk(T_HEAD, 1'b0), 1'b1, 1'b0, 1'b0);
    checkVal("full_pop.ready_in", DW'(bus.ready_in), DW'(1'b0));
    applyStimulus("after_pop", 1'b1, mk(T_HEAD, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Write+pop with count 3, then pop of an empty priority FIFO
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus("single_fill", 1'b1, mk(T_SINGLE, 1'b0), 1'b0, 1'b0, 1'b0);
    applyStimulus("wr_pop", 1'b1, mk(T_SINGLE, 1'b0), 1'b1, 1'b0, 1'b0);
    applyStimulus("prio_empty_pop", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus("count3_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-packet discards state; trailing tail is out of protocol
    doReset();
    applyStimulus("mid_head", 1'b1, mk(T_HEAD, 1'b1), 1'b0, 1'b0, 1'b1);
    doReset();
    applyStimulus("mid_tail", 1'b1, mk(T_TAIL, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("mid_after", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkVal("mid_after.pkt_err", DW'(bus.pkt_err), DW'(1'b1));

    // Random traffic
    doReset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      v   = ($urandom_range(0, 3) != 0);
      t   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      rdR = ($urandom_range(0, 9) < 3);
      rdP = ($urandom_range(0, 9) < 3);
      sel = 1'($urandom);
      applyStimulus("rand", v, mk(t, 1'($urandom)), rdR, rdP, sel);
    end
    applyStimulus("rand_end", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
